adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_adder_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
//
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake on
// both sides. The operand is cut into STAGES equal slices; slice k is summed
// in pipeline stage k (LSB slice first) using 4-bit group generate/propagate
// lookahead. The slice carry-out is registered and becomes the carry-in of
// the next slice one stage later.
//
// Each stage holds one "x" word. Its low bits are the sum bits finished so
// far, and its high bits are the operand-a bits not yet added. A parallel
// b word carries the (already mode-adjusted) b operand forward. When a beat
// leaves the last stage, its x word is the complete sum.
//
// Parameters
//   WIDTH  : operand width. Must be a multiple of 4 in the range 8..128.
//   STAGES : pipeline depth, 1..4. WIDTH must be divisible by 4*STAGES.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset; empties the pipe
//   in_valid   : operand beat present on a/b/cin/sub
//   in_ready   : pipe accepts the beat this cycle (independent of in_valid)
//   a, b       : operands
//   cin        : carry-in
//   sub        : 0 = a + b + cin, 1 = a + ~b + cin
//   out_valid  : result beat present
//   out_ready  : downstream accepts the result
//   sum        : result, modulo 2^WIDTH
//   cout       : carry out of the MSB
//   ovf        : signed overflow (carry into MSB xor carry out of MSB)
//   zero       : sum == 0
// -----------------------------------------------------------------------------
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Slice width and the number of 4-bit lookahead groups in one slice.
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;
  localparam int LAST = STAGES - 1;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] valid_reg;
  logic [WIDTH-1:0]  x_reg     [STAGES];  // {pending a bits, finished sum bits}
  logic [WIDTH-1:0]  b_reg     [STAGES];  // mode-adjusted b operand
  logic [STAGES-1:0] carry_reg;           // carry out of the slice just added
  logic              ovf_reg;
  logic              zero_reg;

  // ---------------------------------------------------------------------------
  // Stage inputs (what stage k will capture) and next-state values
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] st_v;                // beat presented to stage k
  logic [WIDTH-1:0]  st_x      [STAGES];
  logic [WIDTH-1:0]  st_b      [STAGES];
  logic [STAGES-1:0] st_c;                // carry into slice k
  logic [WIDTH-1:0]  nx_x      [STAGES];  // st_x with slice k replaced by sum
  logic [STAGES-1:0] nx_c;                // carry out of slice k

  // Stage k loads when it is empty or everything downstream of it will move
  // this cycle. Written as a reduction over the valid bits rather than a
  // recursive chain so that no bit of load depends on another bit of load.
  logic [STAGES-1:0] load;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_load
      assign load[gi] = out_ready | ~(&valid_reg[STAGES-1:gi]);
    end
  endgenerate

  // in_ready is purely a function of stored state and out_ready. During
  // reset all valid bits are 0, so it reads 1.
  assign in_ready = load[0];

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * SW;

      // Stage 0 takes the ports; subtraction folds into b here so every later
      // stage is a plain adder and the beat's own sub/cin travel with it.
      if (gi == 0) begin : g_first
        assign st_v[gi] = in_valid;
        assign st_x[gi] = a;
        assign st_b[gi] = sub ? ~b : b;
        assign st_c[gi] = cin;
      end else begin : g_next
        assign st_v[gi] = valid_reg[gi-1];
        assign st_x[gi] = x_reg[gi-1];
        assign st_b[gi] = b_reg[gi-1];
        assign st_c[gi] = carry_reg[gi-1];
      end

      // Slice adder: group carries ripple between 4-bit groups, bit carries
      // inside a group come from two-level generate/propagate lookahead.
      logic [WIDTH-1:0] x_next;
      logic             carry_run;
      logic [3:0]       ga;
      logic [3:0]       gb;
      logic [3:0]       gg;
      logic [3:0]       pp;
      logic [3:0]       cc;
      logic             grp_g;
      logic             grp_p;

      always_comb begin
        x_next    = st_x[gi];
        carry_run = st_c[gi];
        ga        = '0;
        gb        = '0;
        gg        = '0;
        pp        = '0;
        cc        = '0;
        grp_g     = 1'b0;
        grp_p     = 1'b0;
        for (int j = 0; j < NG; j++) begin
          ga = st_x[gi][LO + 4*j +: 4];
          gb = st_b[gi][LO + 4*j +: 4];
          gg = ga & gb;
          pp = ga ^ gb;
          cc[0] = carry_run;
          cc[1] = gg[0] | (pp[0] & carry_run);
          cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & carry_run);
          cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                | (pp[2] & pp[1] & pp[0] & carry_run);
          x_next[LO + 4*j +: 4] = pp ^ cc;
          grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                | (pp[3] & pp[2] & pp[1] & gg[0]);
          grp_p = &pp;
          carry_run = grp_g | (grp_p & carry_run);
        end
      end

      assign nx_x[gi] = x_next;
      assign nx_c[gi] = carry_run;
    end
  endgenerate

  // Carry into the MSB is recovered from the MSB sum bit: c[W-1] = a^b^s at
  // bit W-1. ovf = c[W] ^ c[W-1].
  logic last_msb_cin;
  logic ovf_next;
  logic zero_next;

  assign last_msb_cin = st_x[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1] ^ nx_x[LAST][WIDTH-1];
  assign ovf_next     = nx_c[LAST] ^ last_msb_cin;
  assign zero_next    = (nx_x[LAST] == '0);

  // ---------------------------------------------------------------------------
  // Pipeline registers. A stage that loads with no incoming beat becomes a
  // bubble; its data is left alone so the output word only changes when a
  // real beat lands in the last stage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      carry_reg <= '0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        x_reg[k] <= '0;
        b_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_reg[k] <= st_v[k];
          if (st_v[k]) begin
            x_reg[k]     <= nx_x[k];
            b_reg[k]     <= st_b[k];
            carry_reg[k] <= nx_c[k];
          end
        end
      end
      if (load[LAST] && st_v[LAST]) begin
        ovf_reg  <= ovf_next;
        zero_reg <= zero_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: everything comes straight from the last stage, so sum and the
  // flags share timing and hold while the beat is stalled.
  // ---------------------------------------------------------------------------
  assign out_valid = valid_reg[LAST];
  assign sum       = x_reg[LAST];
  assign cout      = carry_reg[LAST];
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
//
// Directed, table-driven bench for adder_pipe at WIDTH=32, STAGES=2.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

  localparam int W  = 32;
  localparam int NV = 12;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  adder_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t tv [NV];
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    a   = tv[i].a;
    b   = tv[i].b;
    cin = tv[i].cin;
    sub = tv[i].sub;
  endtask

  function automatic logic [63:0] result_word();
    return {29'd0, sum, cout, ovf, zero};
  endfunction

  function automatic logic [63:0] expect_word(input int i);
    return {29'd0, tv[i].s, tv[i].co, tv[i].ov, tv[i].z};
  endfunction

  // Streams the first n table vectors through the pipe. out_ready is held
  // low until cycle release_at. Results are checked in order; while stalled
  // the held output must equal the head beat.
  task automatic stream(input int n, input int release_at);
    int idx;
    int got;
    int cyc;
    bit dropped;
    idx     = 0;
    got     = 0;
    cyc     = 0;
    dropped = 1'b0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc >= release_at);
      if (idx < n) begin
        drive(idx);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready)
        chk($sformatf("stall hold beat%0d", got), result_word(), expect_word(got));
      if (out_valid && out_ready) begin
        chk($sformatf("stream beat%0d", got), result_word(), expect_word(got));
        $display("stream beat %0d: sum=%h cout=%b ovf=%b zero=%b", got, sum, cout, ovf, zero);
        got++;
      end
      if (release_at == 0 && idx < n)
        chk($sformatf("stream in_ready c%0d", cyc), {63'd0, in_ready}, 64'd1);
      if (release_at > 0 && cyc == release_at - 1) begin
        chk("bp accepted count", 64'(idx), 64'd2);
        chk("bp in_ready low", {63'd0, in_ready}, 64'd0);
      end
      if (!out_ready && !in_ready && out_valid)
        dropped = 1'b1;
      if (in_valid && in_ready)
        idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream beats out", 64'(got), 64'(n));
    if (release_at > 0)
      chk("bp in_ready dropped", {63'd0, dropped}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;

    //        a             b             cin   sub   sum           cout  ovf   zero
    tv[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tv[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tv[7]  = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tv[8]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tv[9]  = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0, 1'b0};
    tv[10] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tv[11] = '{32'h0000000A, 32'h00000003, 1'b0, 1'b1, 32'h00000006, 1'b1, 1'b0, 1'b0};

    // Reset state, checked while reset is held.
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    #12;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset outputs", result_word(), 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beats: exactly two cycles from the accepting edge to out_valid.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(i);
      in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d in_ready", i), {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d early valid", i), {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d result", i), result_word(), expect_word(i));
      $display("vec %0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b zero=%b",
               i, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, sum, cout, ovf, zero);
    end

    // Back-to-back throughput with no backpressure.
    stream(NV, 0);

    // Backpressure: six beats, out_ready low for the first six cycles.
    stream(6, 6);

    // Reset mid-flight with two beats in the pipe.
    out_ready = 1'b1;
    @(negedge clk);
    drive(0);
    in_valid = 1'b1;
    @(negedge clk);
    drive(9);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid-flight pipe full", {63'd0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("async reset outputs", result_word(), 64'd0);
    chk("async reset in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-reset idle c%0d", c), {63'd0, out_valid}, 64'd0);
    end

    // The pipe still works after the reset.
    @(negedge clk);
    drive(8);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("recovery out_valid", {63'd0, out_valid}, 64'd1);
    chk("recovery result", result_word(), expect_word(8));
    $display("recovery: sum=%h cout=%b ovf=%b zero=%b", sum, cout, ovf, zero);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
